hpspbram_fifo_ctrl: RTL and testbench
=====================================

Name: hpspbram_fifo_ctrl

Overview:
- Sequencing controller that turns the simple dual-port BRAM (write port A, read port B) into a valid/ready streaming FIFO.
- Owns the write and read pointers, occupancy and flow control, and issues BRAM reads ahead of demand.
- Absorbs the BRAM read latency with a small credit-controlled output buffer, so the consumer sees a zero-bubble stream.
- Sits between the snoop/data capture logic (producer) and the downstream consumer; the BRAM instance is external, and this block drives its ports.

Parameters:
- RAM_WIDTH, 678: data word width in bits.
- RAM_DEPTH, 16: BRAM entries; power of two, at least 2.
- RD_LATENCY, 2: cycles from ram_enb/addrb to valid ram_doutb.
  - Legal values are 0 (LOW_LATENCY, combinational read) and 2 (HIGH_PERFORMANCE, output register).
  - Any other value fails elaboration.

Ports:
- clka  in  1  clock.
- rstb  in  1  synchronous active-high reset.
- flush  in  1  synchronous discard of all contents.
- s_valid  in  1  producer word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  RAM_WIDTH  producer word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the output word.
- m_data  out  RAM_WIDTH  output word.
- level  out  $clog2(RAM_DEPTH+RD_LATENCY+2)  total words held.
- ram_addra  out  $clog2(RAM_DEPTH)  BRAM write address.
- ram_wea  out  1  BRAM write enable.
- ram_dina  out  RAM_WIDTH  BRAM write data.
- ram_addrb  out  $clog2(RAM_DEPTH)  BRAM read address.
- ram_enb  out  1  BRAM read enable.
- ram_regceb  out  1  BRAM output register enable.
- ram_rstb  out  1  BRAM output register reset.
- ram_doutb  in  RAM_WIDTH  BRAM read data.

Behaviour:
- Reset: synchronous, active-high rstb on clka.
  - Pointers, in-flight tags and output buffer are cleared.
  - While rstb is high: s_ready=0, m_valid=0, level=0, ram_wea=0, ram_enb=0.
  - m_data is don't-care while m_valid=0.
  - RAM contents are not cleared; they become unreachable.
- BRAM register controls:
  - ram_rstb is driven from rstb | flush.
  - ram_regceb is tied to 1.
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits wide (AW = log2 RAM_DEPTH), so they wrap naturally.
  - bram_cnt = wr_ptr - rd_ptr, range 0..RAM_DEPTH.
  - full = (bram_cnt == RAM_DEPTH).
- Push:
  - s_ready = !full & !rstb & !flush.
  - On s_valid & s_ready, in the same cycle: ram_wea=1, ram_addra=wr_ptr[AW-1:0], ram_dina=s_data; wr_ptr increments at the clock edge.
  - When not pushing, ram_wea=0.
  - s_data is passed combinationally to ram_dina.
- Read issue:
  - OUT_DEPTH = RD_LATENCY+1.
  - credits = OUT_DEPTH - (buffer occupancy + reads in flight).
  - A read issues when bram_cnt > 0, credits > 0, and neither rstb nor flush is high.
  - On issue: ram_enb=1, ram_addrb=rd_ptr[AW-1:0], rd_ptr increments.
  - bram_cnt uses registered pointers only. A word written in cycle t is first eligible for issue in cycle t+1; there is no write-to-read bypass.
- Return:
  - A RD_LATENCY-deep valid shift register tracks issued reads.
  - When a tag matures, ram_doutb is written into the output buffer in that cycle (RD_LATENCY=0: the issue cycle itself).
  - Credits guarantee the buffer never overflows; overflow is an assertion.
- Output:
  - m_valid = output buffer non-empty; m_data = buffer head.
  - m_data is held stable while m_valid & !m_ready.
  - A pop and a capture in the same cycle are both honoured.
- Latency:
  - Push in cycle t gives m_valid at t+RD_LATENCY+2 when the FIFO is empty and m_ready=1.
  - Sustained throughput is 1 word/cycle.
- Simultaneous push and issue: allowed. bram_cnt nets out (+1-1) and is unchanged.
- Level: level = bram_cnt + in-flight + buffer occupancy, updated every cycle; maximum RAM_DEPTH+OUT_DEPTH.
- Flush: same effect as rstb on the controller state in the following cycle.
  - Words pushed in the flush cycle are not accepted (s_ready=0).
  - In-flight returns are dropped.
- Ordering: strict FIFO. Output order equals accept order across pointer wrap-around.

Decomposition:
- Package hpspbram_ctrl_pkg holds:
  - a function returning AW for a depth;
  - the OUT_DEPTH derivation;
  - the legal RD_LATENCY constants (LAT_LOW=0, LAT_HIGH=2).
- One sub-module, hpspbram_out_buf: a parameterised register FIFO of depth OUT_DEPTH with push, pop, head and count.
- The pointer/credit logic stays in the top module.

Test Plan:
- Reset with RD_LATENCY=2, RAM_DEPTH=16, then push 0x1 at cycle 10 with m_ready=1 -> m_valid=1, m_data=0x1 at cycle 14; level goes 1,1,1,1,0.
- m_ready=0, push 19 words 0..18 back-to-back -> s_ready drops after the 19th accept; level=19; no ram_enb after 3 issues; draining yields 0..18 in order.
- Continuous push and pop of 100 incrementing words (pointer wraps 6x) -> output sequence identical, no bubbles after the first word, level constant at steady state.
- RD_LATENCY=0: push 0xA5 at cycle t -> ram_enb at t+1 -> m_valid at t+2 with m_data=0xA5.
- Fill to level=10, assert flush for 1 cycle with s_valid=1 -> that push is not accepted; next cycle level=0, m_valid=0; a subsequent push 0x7 is the first word out.
- rstb asserted mid-stream with reads in flight -> in-flight data is not delivered; after reset, s_ready=1 and level=0, and the first output is the first post-reset push.

Source files
------------

// File: rtl/hpspbram_ctrl_pkg.sv
// Shared constants and helpers for the BRAM-backed streaming FIFO controller.
// Read latencies the controller knows how to absorb, plus sizing helpers.
package hpspbram_ctrl_pkg;

  localparam int LAT_LOW  = 0;
  localparam int LAT_HIGH = 2;

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // One slot per cycle of read latency plus the word being presented.
  function automatic int out_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/hpspbram_out_buf.sv
// Small register FIFO that catches BRAM read returns and presents the head word.
// Simultaneous push and pop are both honoured; the credit logic upstream prevents overflow.
module hpspbram_out_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clka,
  input  logic                       rstb,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [IW-1:0]    wr_idx_reg;
  logic [IW-1:0]    rd_idx_reg;
  logic [CW-1:0]    count_reg;

  function automatic logic [IW-1:0] bump(input logic [IW-1:0] idx);
    return (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
  endfunction

  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_idx_reg <= bump(wr_idx_reg);
      if (pop)  rd_idx_reg <= bump(rd_idx_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Data storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clka) begin
    if (push) mem_reg[wr_idx_reg] <= push_data;
  end

  always_ff @(posedge clka) begin
    if (!rstb) assert (!(push && !pop && count_reg == CW'(DEPTH)));
  end

  assign head  = mem_reg[rd_idx_reg];
  assign count = count_reg;

endmodule

// File: rtl/hpspbram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external simple dual-port BRAM.
// Reads are issued ahead of demand against output-buffer credits so the consumer sees no bubbles.
module hpspbram_fifo_ctrl
  import hpspbram_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH  = 678,
  parameter int RAM_DEPTH  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                                        clka,
  input  logic                                        rstb,
  input  logic                                        flush,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  input  logic [RAM_WIDTH-1:0]                        s_data,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic [RAM_WIDTH-1:0]                        m_data,
  output logic [$clog2(RAM_DEPTH+RD_LATENCY+2)-1:0]   level,
  output logic [$clog2(RAM_DEPTH)-1:0]                ram_addra,
  output logic                                        ram_wea,
  output logic [RAM_WIDTH-1:0]                        ram_dina,
  output logic [$clog2(RAM_DEPTH)-1:0]                ram_addrb,
  output logic                                        ram_enb,
  output logic                                        ram_regceb,
  output logic                                        ram_rstb,
  input  logic [RAM_WIDTH-1:0]                        ram_doutb
);

  localparam int AW        = addr_width(RAM_DEPTH);
  localparam int OUT_DEPTH = out_depth(RD_LATENCY);
  localparam int CW        = $clog2(OUT_DEPTH + 1);
  localparam int LW        = $clog2(RAM_DEPTH + RD_LATENCY + 2);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(RAM_DEPTH);
  localparam logic [CW:0] OUT_SLOTS = (CW + 1)'(OUT_DEPTH);

  if (!(RD_LATENCY == LAT_LOW || RD_LATENCY == LAT_HIGH)) begin : g_bad_latency
    $error("hpspbram_fifo_ctrl: RD_LATENCY must be 0 or 2");
  end
  if (RAM_DEPTH < 2 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hpspbram_fifo_ctrl: RAM_DEPTH must be a power of two >= 2");
  end

  logic          clear;
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW:0]   bram_cnt;
  logic          full;
  logic          push;
  logic          issue;
  logic          capture;
  logic          pop;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] inflight;

  assign clear    = rstb | flush;
  assign bram_cnt = wr_ptr_reg - rd_ptr_reg;
  assign full     = (bram_cnt == FULL_CNT);

  assign s_ready = !full && !clear;
  assign push    = s_valid && s_ready;
  assign m_valid = (buf_count != '0) && !rstb;
  assign pop     = m_valid && m_ready;

  // A slot freed by this cycle's pop is already usable for this cycle's issue.
  assign issue = (bram_cnt != '0) && !clear &&
                 (({1'b0, buf_count} + {1'b0, inflight}) < (OUT_SLOTS + {{CW{1'b0}}, pop}));

  always_ff @(posedge clka) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      if (issue) rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
    end
  end

  if (RD_LATENCY == 0) begin : g_comb_read
    assign capture  = issue;
    assign inflight = '0;
  end else begin : g_tagged_read
    logic [RD_LATENCY-1:0] tag_reg;

    always_ff @(posedge clka) begin
      if (clear) tag_reg <= '0;
      else       tag_reg <= (tag_reg << 1) | RD_LATENCY'(issue);
    end

    assign capture = tag_reg[RD_LATENCY-1];

    always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(tag_reg[i]);
    end
  end

  hpspbram_out_buf #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_buf (
    .clka      (clka),
    .rstb      (clear),
    .push      (capture),
    .push_data (ram_doutb),
    .pop       (pop),
    .head      (m_data),
    .count     (buf_count)
  );

  assign ram_wea    = push;
  assign ram_addra  = wr_ptr_reg[AW-1:0];
  assign ram_dina   = s_data;
  assign ram_enb    = issue;
  assign ram_addrb  = rd_ptr_reg[AW-1:0];
  assign ram_regceb = 1'b1;
  assign ram_rstb   = clear;

  assign level = rstb ? '0 : (LW'(bram_cnt) + LW'(inflight) + LW'(buf_count));

endmodule

// File: tb/tb_hpspbram_fifo_ctrl.sv
// Bench for hpspbram_fifo_ctrl: one RD_LATENCY=2 and one RD_LATENCY=0 instance, each with a BRAM model.
// A queue of accepted words and an accepted-minus-delivered count serve as the reference.
module tb_hpspbram_fifo_ctrl;

  localparam int W   = 678;
  localparam int D   = 16;
  localparam int AW  = $clog2(D);
  localparam int LW2 = $clog2(D + 2 + 2);
  localparam int LW0 = $clog2(D + 0 + 2);

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic rstb, flush;

  logic           s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0]   s_data, m_data;
  logic [LW2-1:0] level;
  logic [AW-1:0]  ram_addra, ram_addrb;
  logic           ram_wea, ram_enb, ram_regceb, ram_rstb;
  logic [W-1:0]   ram_dina, ram_doutb;

  logic           s_valid0, s_ready0, m_valid0, m_ready0;
  logic [W-1:0]   s_data0, m_data0;
  logic [LW0-1:0] level0;
  logic [AW-1:0]  ram0_addra, ram0_addrb;
  logic           ram0_wea, ram0_enb, ram0_regceb, ram0_rstb;
  logic [W-1:0]   ram0_dina, ram0_doutb;

  hpspbram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(2)) u_dut (
    .clka(clka), .rstb(rstb), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
    .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb),
    .ram_rstb(ram_rstb), .ram_doutb(ram_doutb)
  );

  hpspbram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(0)) u_dut0 (
    .clka(clka), .rstb(rstb), .flush(flush),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .level(level0),
    .ram_addra(ram0_addra), .ram_wea(ram0_wea), .ram_dina(ram0_dina),
    .ram_addrb(ram0_addrb), .ram_enb(ram0_enb), .ram_regceb(ram0_regceb),
    .ram_rstb(ram0_rstb), .ram_doutb(ram0_doutb)
  );

  // BRAM model, high-performance mode: array read stage then output register.
  logic [W-1:0] mem2 [D];
  logic [W-1:0] rd_stage;
  always @(posedge clka) begin
    if (ram_wea) mem2[ram_addra] <= ram_dina;
    if (ram_enb) rd_stage <= mem2[ram_addrb];
    if (ram_rstb) ram_doutb <= '0;
    else if (ram_regceb) ram_doutb <= rd_stage;
  end

  // BRAM model, low-latency mode: combinational read.
  logic [W-1:0] mem0 [D];
  always @(posedge clka) begin
    if (ram0_wea) mem0[ram0_addra] <= ram0_dina;
  end
  assign ram0_doutb = mem0[ram0_addrb];

  int n_vec = 0;
  int n_err = 0;

  logic           obs_s_ready, obs_m_valid, obs_wea, obs_enb;
  logic [W-1:0]   obs_m_data;
  logic [LW2-1:0] obs_level;
  logic           obs0_s_ready, obs0_m_valid, obs0_enb;
  logic [W-1:0]   obs0_m_data;
  logic [LW0-1:0] obs0_level;
  int             exp_level;
  int             mdl_level = 0;
  logic [W-1:0]   ref_q[$];
  logic [W-1:0]   got_q[$];
  logic [W-1:0]   exp_out_q[$];

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    repeat (22) w = {w[W-33:0], 32'($urandom)};
    return w;
  endfunction

  // Advance one cycle: sample at the falling edge, update the reference, return just after the rising edge.
  task automatic tick();
    logic acc, popd;
    @(negedge clka);
    obs_s_ready  = s_ready;  obs_m_valid  = m_valid;  obs_m_data  = m_data;
    obs_level    = level;    obs_wea      = ram_wea;  obs_enb     = ram_enb;
    obs0_s_ready = s_ready0; obs0_m_valid = m_valid0; obs0_m_data = m_data0;
    obs0_level   = level0;   obs0_enb     = ram0_enb;
    exp_level = rstb ? 0 : mdl_level;
    acc  = s_valid && s_ready;
    popd = m_valid && m_ready;
    if (popd) begin
      got_q.push_back(m_data);
      if (ref_q.size() > 0) exp_out_q.push_back(ref_q.pop_front());
      else exp_out_q.push_back({W{1'b1}});
    end
    if (rstb || flush) begin
      ref_q.delete();
      mdl_level = 0;
    end else begin
      if (acc) ref_q.push_back(s_data);
      mdl_level = mdl_level + int'(acc) - int'(popd);
    end
    @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b1; flush = 1'b0;
    s_valid = 1'b1; s_data = rand_word(); m_ready = 1'b1;
    s_valid0 = 1'b1; s_data0 = rand_word(); m_ready0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (obs_s_ready !== 1'b0 || obs_m_valid !== 1'b0 || obs_level !== '0 ||
          obs_wea !== 1'b0 || obs_enb !== 1'b0)
        begin n_err++; $display("FAIL reset_outputs: s_ready=%b m_valid=%b level=%0d wea=%b enb=%b, expected 0 0 0 0 0",
                                obs_s_ready, obs_m_valid, obs_level, obs_wea, obs_enb); end
      n_vec++;
      if (obs0_s_ready !== 1'b0 || obs0_m_valid !== 1'b0 || obs0_enb !== 1'b0)
        begin n_err++; $display("FAIL reset_outputs_lat0: s_ready=%b m_valid=%b enb=%b, expected 0 0 0",
                                obs0_s_ready, obs0_m_valid, obs0_enb); end
    end
    rstb = 1'b0; s_valid = 1'b0; s_valid0 = 1'b0;
    tick();
    n_vec++;
    if (obs_s_ready !== 1'b1 || obs_level !== '0 || obs_m_valid !== 1'b0)
      begin n_err++; $display("FAIL after_reset: s_ready=%b level=%0d m_valid=%b, expected 1 0 0",
                              obs_s_ready, obs_level, obs_m_valid); end
  endtask

  task automatic test_first_word();
    int lvl_tab[5];
    logic mv_tab[5];
    lvl_tab = '{1, 1, 1, 1, 0};
    mv_tab  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    repeat (5) tick();
    m_ready = 1'b1; s_valid = 1'b1; s_data = W'(1);
    tick();
    n_vec++;
    if (obs_s_ready !== 1'b1) begin n_err++; $display("FAIL first_push_ready: got %b, expected 1", obs_s_ready); end
    s_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (obs_level !== LW2'(lvl_tab[k]))
        begin n_err++; $display("FAIL first_level[t+%0d]: got %0d, expected %0d", k + 1, obs_level, lvl_tab[k]); end
      n_vec++;
      if (obs_m_valid !== mv_tab[k])
        begin n_err++; $display("FAIL first_m_valid[t+%0d]: got %b, expected %b", k + 1, obs_m_valid, mv_tab[k]); end
      if (k == 0) begin
        n_vec++;
        if (obs_enb !== 1'b1) begin n_err++; $display("FAIL first_issue: ram_enb=%b, expected 1", obs_enb); end
      end
      if (k == 3) begin
        n_vec++;
        if (obs_m_data !== W'(1))
          begin n_err++; $display("FAIL first_data: got %0h, expected 1", obs_m_data[31:0]); end
      end
    end
  endtask

  task automatic test_fill();
    int acc_n = 0, enb_n = 0;
    logic exp_rdy;
    m_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      s_valid = 1'b1; s_data = W'(acc_n);
      tick();
      if (obs_enb) enb_n++;
      exp_rdy = (c < 19);
      n_vec++;
      if (obs_s_ready !== exp_rdy)
        begin n_err++; $display("FAIL fill_s_ready[c%0d]: got %b, expected %b", c, obs_s_ready, exp_rdy); end
      if (obs_s_ready) acc_n++;
    end
    s_valid = 1'b0;
    tick();
    if (obs_enb) enb_n++;
    n_vec++;
    if (enb_n != 3) begin n_err++; $display("FAIL fill_issues: got %0d reads, expected 3", enb_n); end
    n_vec++;
    if (obs_level !== LW2'(19)) begin n_err++; $display("FAIL fill_level: got %0d, expected 19", obs_level); end
    got_q.delete(); exp_out_q.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 80 && got_q.size() < 19; c++) tick();
    n_vec++;
    if (got_q.size() != 19) begin n_err++; $display("FAIL fill_drain_count: got %0d words, expected 19", got_q.size()); end
    for (int i = 0; i < 19 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== W'(i)) begin n_err++; $display("FAIL fill_order[%0d]: got %0h, expected %0h", i, got_q[i][31:0], i); end
    end
  endtask

  task automatic test_stream();
    int sent = 0, bubbles = 0, lvl_bad = 0, ord_bad = 0;
    logic started = 1'b0;
    got_q.delete(); exp_out_q.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 300 && got_q.size() < 100; c++) begin
      s_valid = (sent < 100); s_data = W'(1000 + sent);
      tick();
      if (s_valid && obs_s_ready) sent++;
      if (obs_m_valid) started = 1'b1;
      else if (started && got_q.size() < 100) bubbles++;
      if (started && s_valid && obs_level !== LW2'(4)) begin
        if (lvl_bad == 0) $display("FAIL stream_level[c%0d]: got %0d, expected 4", c, obs_level);
        lvl_bad++;
      end
    end
    s_valid = 1'b0;
    n_vec++;
    if (got_q.size() != 100) begin n_err++; $display("FAIL stream_count: got %0d, expected 100", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== W'(1000 + i)) begin
        if (ord_bad == 0) $display("FAIL stream_order[%0d]: got %0h, expected %0h", i, got_q[i][31:0], 1000 + i);
        ord_bad++;
      end
    end
    n_vec++; if (ord_bad != 0) n_err++;
    n_vec++;
    if (bubbles != 0) begin n_err++; $display("FAIL stream_bubbles: got %0d, expected 0", bubbles); end
    n_vec++; if (lvl_bad != 0) n_err++;
  endtask

  task automatic test_random();
    int lvl_bad = 0, hold_bad = 0, ord_bad = 0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    got_q.delete(); exp_out_q.delete();
    for (int c = 0; c < 600; c++) begin
      s_valid = (c < 500) ? ($urandom_range(3, 0) != 0) : 1'b0;
      s_data  = rand_word();
      if (c < 150)      m_ready = ($urandom_range(3, 0) == 0);
      else if (c < 350) m_ready = $urandom_range(1, 0) != 0;
      else              m_ready = ($urandom_range(7, 0) != 0);
      tick();
      if (obs_level !== LW2'(exp_level)) begin
        if (lvl_bad == 0) $display("FAIL rand_level[c%0d]: got %0d, expected %0d", c, obs_level, exp_level);
        lvl_bad++;
      end
      if (prev_stall && (obs_m_valid !== 1'b1 || obs_m_data !== prev_data)) begin
        if (hold_bad == 0) $display("FAIL rand_hold[c%0d]: m_valid=%b data=%0h, expected 1 %0h",
                                    c, obs_m_valid, obs_m_data[31:0], prev_data[31:0]);
        hold_bad++;
      end
      prev_stall = obs_m_valid && !m_ready;
      prev_data  = obs_m_data;
    end
    n_vec++; if (lvl_bad != 0) n_err++;
    n_vec++; if (hold_bad != 0) n_err++;
    n_vec++;
    if (got_q.size() != exp_out_q.size() || ref_q.size() != 0 || mdl_level != 0)
      begin n_err++; $display("FAIL rand_drain: delivered %0d, undelivered %0d, expected all delivered", got_q.size(), ref_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_out_q.size(); i++) begin
      if (got_q[i] !== exp_out_q[i]) begin
        if (ord_bad == 0) $display("FAIL rand_order[%0d]: got %0h, expected %0h", i, got_q[i][31:0], exp_out_q[i][31:0]);
        ord_bad++;
      end
    end
    n_vec++; if (ord_bad != 0) n_err++;
  endtask

  task automatic test_flush();
    int acc_n = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 30 && acc_n < 10; c++) begin
      s_valid = 1'b1; s_data = rand_word();
      tick();
      if (obs_s_ready) acc_n++;
    end
    s_valid = 1'b0;
    tick();
    n_vec++;
    if (obs_level !== LW2'(10)) begin n_err++; $display("FAIL flush_prefill_level: got %0d, expected 10", obs_level); end
    flush = 1'b1; s_valid = 1'b1; s_data = W'(16'hdead);
    tick();
    n_vec++;
    if (obs_s_ready !== 1'b0) begin n_err++; $display("FAIL flush_s_ready: got %b, expected 0", obs_s_ready); end
    flush = 1'b0; s_valid = 1'b0;
    tick();
    n_vec++;
    if (obs_level !== '0 || obs_m_valid !== 1'b0)
      begin n_err++; $display("FAIL flush_cleared: level=%0d m_valid=%b, expected 0 0", obs_level, obs_m_valid); end
    got_q.delete(); exp_out_q.delete();
    m_ready = 1'b1; s_valid = 1'b1; s_data = W'(7);
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 12 && got_q.size() == 0; c++) tick();
    n_vec++;
    if (got_q.size() == 0) begin n_err++; $display("FAIL flush_first_out: got no word, expected 7"); end
    else if (got_q[0] !== W'(7)) begin n_err++; $display("FAIL flush_first_out: got %0h, expected 7", got_q[0][31:0]); end
    repeat (4) tick();
  endtask

  task automatic test_reset_midstream();
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1; s_data = W'(500 + c);
      tick();
    end
    n_vec++;
    if (obs_enb !== 1'b1) begin n_err++; $display("FAIL midreset_inflight: ram_enb=%b, expected 1", obs_enb); end
    rstb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (obs_s_ready !== 1'b0 || obs_m_valid !== 1'b0 || obs_level !== '0 || obs_wea !== 1'b0)
        begin n_err++; $display("FAIL midreset_outputs: s_ready=%b m_valid=%b level=%0d wea=%b, expected 0 0 0 0",
                                obs_s_ready, obs_m_valid, obs_level, obs_wea); end
    end
    rstb = 1'b0; s_valid = 1'b0;
    got_q.delete(); exp_out_q.delete();
    tick();
    n_vec++;
    if (obs_s_ready !== 1'b1 || obs_level !== '0 || obs_m_valid !== 1'b0)
      begin n_err++; $display("FAIL midreset_after: s_ready=%b level=%0d m_valid=%b, expected 1 0 0",
                              obs_s_ready, obs_level, obs_m_valid); end
    s_valid = 1'b1; s_data = W'(8'h55);
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 12 && got_q.size() == 0; c++) tick();
    n_vec++;
    if (got_q.size() == 0) begin n_err++; $display("FAIL midreset_first_out: got no word, expected 55"); end
    else if (got_q[0] !== W'(8'h55)) begin n_err++; $display("FAIL midreset_first_out: got %0h, expected 55", got_q[0][31:0]); end
    repeat (4) tick();
  endtask

  task automatic test_lat0();
    int sent = 0, n_got = 0, bubbles = 0, ord_bad = 0;
    logic started = 1'b0;
    m_ready0 = 1'b1; s_valid0 = 1'b1; s_data0 = W'(8'hA5);
    tick();
    n_vec++;
    if (obs0_s_ready !== 1'b1 || obs0_enb !== 1'b0)
      begin n_err++; $display("FAIL lat0_push: s_ready=%b enb=%b, expected 1 0", obs0_s_ready, obs0_enb); end
    s_valid0 = 1'b0;
    tick();
    n_vec++;
    if (obs0_enb !== 1'b1 || obs0_m_valid !== 1'b0)
      begin n_err++; $display("FAIL lat0_issue: enb=%b m_valid=%b, expected 1 0", obs0_enb, obs0_m_valid); end
    tick();
    n_vec++;
    if (obs0_m_valid !== 1'b1 || obs0_m_data !== W'(8'hA5))
      begin n_err++; $display("FAIL lat0_out: m_valid=%b data=%0h, expected 1 a5", obs0_m_valid, obs0_m_data[31:0]); end
    tick();
    n_vec++;
    if (obs0_m_valid !== 1'b0 || obs0_level !== '0)
      begin n_err++; $display("FAIL lat0_empty: m_valid=%b level=%0d, expected 0 0", obs0_m_valid, obs0_level); end
    for (int c = 0; c < 80 && n_got < 20; c++) begin
      s_valid0 = (sent < 20); s_data0 = W'(200 + sent);
      tick();
      if (s_valid0 && obs0_s_ready) sent++;
      if (obs0_m_valid) begin
        if (obs0_m_data !== W'(200 + n_got)) begin
          if (ord_bad == 0) $display("FAIL lat0_order[%0d]: got %0h, expected %0h", n_got, obs0_m_data[31:0], 200 + n_got);
          ord_bad++;
        end
        n_got++;
        started = 1'b1;
      end else if (started) begin
        bubbles++;
      end
    end
    s_valid0 = 1'b0;
    n_vec++;
    if (n_got != 20) begin n_err++; $display("FAIL lat0_count: got %0d, expected 20", n_got); end
    n_vec++; if (ord_bad != 0) n_err++;
    n_vec++;
    if (bubbles != 0) begin n_err++; $display("FAIL lat0_bubbles: got %0d, expected 0", bubbles); end
  endtask

  initial begin
    rstb = 1'b1; flush = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    s_valid0 = 1'b0; s_data0 = '0; m_ready0 = 1'b0;
    @(posedge clka);
    #1;
    test_reset();
    test_first_word();
    test_fill();
    test_stream();
    test_random();
    test_flush();
    test_reset_midstream();
    test_lat0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
